mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the single unified instruction/data memory between two requesters: the IF-stage instruction fetch and the MEM-stage load/store.
- Sequences each access through a request/grant/ack handshake.
- Exposes per-port stall signals to the pipeline.
- Honours the processor HALTED flag, times out on a dead memory, and returns read data as a registered one-cycle valid pulse.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 15, maximum cycles waiting for mem_ack before abort (>=1).
- STARVE_MAX, 4, consecutive data wins while fetch waits before fetch is forced (used only with the optional feature).

Ports:
- clk1  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- halted  in  1  processor HALTED flag; blocks new fetch grants.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  AW  fetch word address.
- if_gnt  out  1  fetch accepted (combinational, IDLE only).
- if_valid  out  1  one-cycle pulse, fetch data ready.
- if_rdata  out  DW  fetched instruction, valid with if_valid.
- if_stall  out  1  if_req & ~if_gnt & ~halted.
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data word address.
- dm_wdata  in  DW  store data.
- dm_gnt  out  1  data accepted (combinational, IDLE only).
- dm_valid  out  1  one-cycle pulse, load data ready or store done.
- dm_rdata  out  DW  load data; 0 for stores.
- dm_stall  out  1  dm_req & ~dm_gnt.
- mem_req  out  1  memory access strobe, held until ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, sampled on mem_ack.
- mem_ack  in  1  access complete.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async, rst_n=0): all registered outputs go to 0, the state machine goes to IDLE, and the timeout counter and owner flag clear. An in-flight access is dropped with no valid pulse; mem_req falls immediately.
- States are IDLE and BUSY.
- IDLE, winner selection:
  - If dm_req=1, data wins.
  - Otherwise, if if_req=1 & halted=0, fetch wins.
  - The winner's gnt is asserted combinationally in the same cycle.
- IDLE, on the clock edge after a grant:
  - Latch addr/we/wdata (fetch: we=0, wdata=0) and record the owner.
  - Set mem_req=1 and go to BUSY.
- IDLE with no qualifying request: stay in IDLE, mem_req=0.
- Both gnt outputs are 0 in BUSY and are never high together.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - The timeout counter increments each cycle that mem_ack=0.
- mem_ack=1 in BUSY, on that edge:
  - Drop mem_req and return to IDLE.
  - Register mem_rdata to the owner's rdata; for a store owner, dm_rdata=0.
  - Pulse the owner's valid for exactly 1 cycle.
- A new grant may be given in the IDLE cycle that the valid pulse is high (back-to-back).
- Latency: gnt at cycle N, mem_req high from N+1, ack at N+1+k (k>=0), valid at N+2+k.
- Timeout: if the counter reaches TIMEOUT with no ack, drop mem_req, return to IDLE, pulse err, and give no valid pulse. The owner's request is not retried.
- mem_ack outside BUSY is ignored.
- halted=1: no new fetch grants are given and if_stall=0. A fetch already in BUSY completes normally. Data requests are unaffected.
- The rdata outputs hold their last value between valid pulses.
- Address and data pass through unmodified; there is no width conversion.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- With the macro defined:
  - A counter counts consecutive data grants issued while if_req=1 & halted=0.
  - When it reaches STARVE_MAX, the next IDLE arbitration grants fetch even if dm_req=1, and the counter clears.
  - The counter also clears on any fetch grant, and whenever if_req=0 or halted=1.
- Without the macro: fixed data-over-fetch priority, and no counter logic exists.

Test Plan:
- Single fetch: if_req=1, if_addr=0, ack 1 cycle after mem_req, mem_rdata=32'h28010078 -> if_gnt at N, mem_req/mem_addr=0 at N+1, if_valid at N+3 with if_rdata=32'h28010078.
- Load/store: dm load addr 120, mem_rdata=85 -> dm_valid with dm_rdata=85. Then store addr 121, wdata=130 -> mem_we=1, mem_wdata=130, dm_valid pulse, dm_rdata=0.
- Simultaneous if_req and dm_req in IDLE -> dm_gnt first and if_stall=1 throughout. if_gnt follows in the IDLE cycle carrying dm_valid.
- Halt: halted=1 with if_req=1 -> no if_gnt and if_stall=0. Assert halted during a BUSY fetch -> that fetch still produces if_valid.
- Timeout and reset: mem_ack held 0 -> err pulse after TIMEOUT=15 BUSY cycles, no valid, state IDLE. Separately, rst_n=0 mid-BUSY -> mem_req=0 immediately, no valid after release.
- With MEM_ARB_STARVE_GUARD_EN, dm_req and if_req both held high -> grant order is data x4, then fetch, then data again.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: unified memory arbiter for IF fetch and MEM load/store with timeout abort.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_MAX consecutive data wins.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          halted,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_valid,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t        r_state;
    logic          r_owner_dm;
    logic [TW-1:0] r_tcnt;
    logic          w_idle;
    logic          w_force;
    logic          w_if_win;
    logic          w_dm_win;
    assign w_idle   = r_state == IDLE;
    assign w_if_win = w_idle & if_req & ~halted & (~dm_req | w_force);
    assign w_dm_win = w_idle & dm_req & ~w_if_win;
    assign if_gnt   = w_if_win;
    assign dm_gnt   = w_dm_win;
    assign if_stall = if_req & ~w_if_win & ~halted;
    assign dm_stall = dm_req & ~w_dm_win;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] r_starve;
    assign w_force = r_starve == SW'(STARVE_MAX);
    // Only data wins taken while a live fetch waits count toward starvation
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) r_starve <= '0;
        else if (!if_req || halted || w_if_win) r_starve <= '0;
        else if (w_dm_win) r_starve <= r_starve + 1'b1;
    end
`else
    assign w_force = STARVE_MAX < 0;
`endif
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner_dm <= 1'b0;
            r_tcnt     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_valid   <= 1'b0;
            if_rdata   <= '0;
            dm_valid   <= 1'b0;
            dm_rdata   <= '0;
            err        <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            err      <= 1'b0;
            if (w_idle) begin
                r_tcnt <= '0;
                if (w_if_win || w_dm_win) begin
                    r_state    <= BUSY;
                    r_owner_dm <= w_dm_win;
                    mem_req    <= 1'b1;
                    mem_we     <= w_dm_win & dm_we;
                    mem_addr   <= w_dm_win ? dm_addr : if_addr;
                    mem_wdata  <= w_dm_win ? dm_wdata : '0;
                end
            end else if (mem_ack) begin
                r_state <= IDLE;
                mem_req <= 1'b0;
                if (r_owner_dm) begin
                    dm_valid <= 1'b1;
                    dm_rdata <= mem_we ? '0 : mem_rdata;
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= mem_rdata;
                end
            end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                // TIMEOUT ack-less BUSY cycles: abandon the access without retry
                r_state <= IDLE;
                mem_req <= 1'b0;
                err     <= 1'b1;
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus randomized transaction checks of mem_port_arbiter
// against a transaction-level model (grant priority, latency, timeout, reset, starvation guard).
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 32, TIMEOUT = 15, STARVE_MAX = 4;
    logic clk1 = 0, rst_n = 0, halted = 0;
    logic if_req = 0, dm_req = 0, dm_we = 0, mem_ack = 0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
    logic if_gnt, if_valid, if_stall, dm_gnt, dm_valid, dm_stall, mem_req, mem_we, err;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] last_if = '0, last_dm = '0;
    int checks = 0, errors = 0;

    always #5 clk1 = ~clk1;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk1(clk1), .rst_n(rst_n), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // One access from a single requester: grant at N, memory ack k cycles after mem_req rises, valid at N+2+k
    task automatic access(input bit dm, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd, input int k, input bit hlt);
        if (dm) begin dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wd; end
        else begin if_req = 1; if_addr = addr; end
        #1;
        chk("gnt", {if_gnt, dm_gnt}, dm ? 2'b01 : 2'b10);
        chk("stall", {if_stall, dm_stall}, 2'b00);
        tick();
        {if_req, dm_req, dm_we} = '0;
        if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
        if (hlt) halted = 1;
        chk("mem_we", mem_we, dm & we);
        chk("mem_wdata", mem_wdata, dm ? wd : '0);
        for (int i = 0; i <= k; i++) begin
            chk("busy", {mem_req, if_gnt, dm_gnt, if_valid, dm_valid, err}, 6'b100000);
            chk("mem_addr", mem_addr, addr);
            if (i == k) begin mem_ack = 1; mem_rdata = rd; end
            else mem_rdata = $urandom;
            tick();
        end
        mem_ack = 0; mem_rdata = $urandom;
        if (dm) last_dm = we ? '0 : rd; else last_if = rd;
        chk("valid", {if_valid, dm_valid, err, mem_req}, dm ? 4'b0100 : 4'b1000);
        chk("if_rdata", if_rdata, last_if);
        chk("dm_rdata", dm_rdata, last_dm);
        tick();
        chk("pulse_end", {if_valid, dm_valid, mem_req}, 3'b000);
        chk("rdata_hold", {if_rdata, dm_rdata}, {last_if, last_dm});
        halted = 0;
    endtask

    initial begin
        int n;
        bit got[$];
        logic [5:0] order, exp_order;
        repeat (2) @(posedge clk1);
        #1;
        chk("rst_ctl", {if_gnt, if_valid, if_stall, dm_gnt, dm_valid, dm_stall, mem_req, mem_we, err}, 9'd0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
        chk("rst_mem", {mem_addr, mem_wdata}, 64'd0);
        @(negedge clk1) rst_n = 1;
        tick();

        access(0, 0, 32'd0, 32'd0, 32'h28010078, 1, 0);
        access(1, 0, 32'd120, 32'd0, 32'd85, 0, 0);
        access(1, 1, 32'd121, 32'd130, 32'hDEADBEEF, 2, 0);

        mem_ack = 1; mem_rdata = 32'h1234;
        repeat (2) begin
            tick();
            chk("stray_ack", {mem_req, if_valid, dm_valid, err}, 4'b0000);
        end
        mem_ack = 0;

        if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h80;
        #1;
        chk("both_gnt", {if_gnt, dm_gnt, if_stall, dm_stall}, 4'b0110);
        tick();
        dm_req = 0;
        chk("both_busy", {mem_req, mem_addr == 32'h80, mem_we, if_stall, if_gnt}, 5'b11010);
        mem_ack = 1; mem_rdata = 32'h55;
        tick();
        mem_ack = 0;
        last_dm = 32'h55;
        chk("b2b", {dm_valid, if_gnt, if_stall, dm_rdata}, {3'b110, 32'h55});
        tick();
        if_req = 0;
        chk("b2b_fetch", {mem_req, mem_we, mem_addr}, {2'b10, 32'h40});
        mem_ack = 1; mem_rdata = 32'h66;
        tick();
        mem_ack = 0;
        last_if = 32'h66;
        chk("b2b_valid", {if_valid, dm_valid, if_rdata}, {2'b10, 32'h66});
        tick();

        halted = 1; if_req = 1; if_addr = 32'h99;
        repeat (3) begin
            #1;
            chk("halt_block", {if_gnt, if_stall, mem_req}, 3'b000);
            tick();
        end
        if_req = 0;
        access(1, 0, 32'h200, 32'd0, 32'h77, 1, 0);
        access(0, 0, 32'h300, 32'd0, 32'h88, 2, 1);

        for (int t = 0; t < 30; t++) begin
            int kind;
            kind = $urandom_range(0, 2);
            access(kind != 0, kind == 2, $urandom, $urandom, $urandom, $urandom_range(0, 4),
                   kind == 0 && $urandom_range(0, 1) == 1);
        end

        dm_req = 1; dm_we = 1; dm_addr = 32'h500; dm_wdata = 32'h5;
        tick();
        dm_req = 0;
        n = 0;
        while (mem_req && n < 40) begin n++; tick(); end
        chk("timeout_cycles", n, TIMEOUT);
        chk("timeout_err", {err, if_valid, dm_valid, mem_req}, 4'b1000);
        tick();
        chk("timeout_pulse", {err, if_valid, dm_valid}, 3'b000);
        access(0, 0, 32'h600, 32'd0, 32'h99, 0, 0);

        if_req = 1; if_addr = 32'h700;
        tick();
        if_req = 0;
        chk("pre_rst_busy", mem_req, 1'b1);
        #2 rst_n = 0;
        #1;
        chk("rst_async", {mem_req, if_valid, dm_valid, err}, 4'b0000);
        mem_ack = 1; mem_rdata = 32'hAAAA;
        @(negedge clk1) rst_n = 1;
        last_if = '0; last_dm = '0;
        repeat (2) begin
            tick();
            chk("rst_no_valid", {mem_req, if_valid, dm_valid, err}, 4'b0000);
            chk("rst_rdata_clr", {if_rdata, dm_rdata}, {last_if, last_dm});
        end
        mem_ack = 0;

        if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h20; mem_rdata = '0;
        n = 0;
        while (got.size() < 6 && n < 60) begin
            mem_ack = mem_req;
            #1;
            chk("one_hot_gnt", if_gnt & dm_gnt, 1'b0);
            if (dm_gnt) got.push_back(1'b1);
            else if (if_gnt) got.push_back(1'b0);
            tick();
            n++;
        end
        if_req = 0; dm_req = 0; mem_ack = 1;
        order = '0;
        foreach (got[i]) order[5 - i] = got[i];
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_order = 6'b111101;
`else
        exp_order = 6'b111111;
`endif
        chk("grant_count", got.size(), 6);
        chk("grant_order", order, exp_order);
        tick();
        mem_ack = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
